dmem_responder: RTL and testbench

//   Data-memory responder for the MEM stage of the five-stage pipeline.

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Core <-> data-memory request/response bus for the MEM stage.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency RV32I data-memory responder: one load/store per transaction,
// memory action happens on the single edge that enters RESP.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus,
  output logic   busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [2**ADDR_W];

  logic              accept, enter;
  logic              s_we;
  logic [2:0]        s_f3;
  logic [31:0]       s_addr, s_wd;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       word, sh, ld, wrep, rd_next;
  logic [3:0]        wmask;
  logic              err, do_write;
  logic              addr_unused;

  // Entry-edge operands: with LATENCY=1 the entry edge is the accept edge,
  // so the live request fields are used instead of the latched copy.
  always_comb begin
    accept = (state == IDLE) && bus.req_valid && bus.req_ready;
    enter  = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd1));
    s_we   = (LATENCY == 1) ? bus.req_we     : we_q;
    s_f3   = (LATENCY == 1) ? bus.req_funct3 : f3_q;
    s_addr = (LATENCY == 1) ? bus.req_addr   : addr_q;
    s_wd   = (LATENCY == 1) ? bus.req_wdata  : wdata_q;
    // upper address bits are dropped so the index wraps modulo depth
    idx    = s_addr[ADDR_W+1:2];
    addr_unused = ^s_addr[31:ADDR_W+2];

    err = 1'b0;
    if (s_we) begin
      if (s_f3 > 3'd2) err = 1'b1;
    end else if (s_f3 == 3'd3 || s_f3 == 3'd6 || s_f3 == 3'd7) begin
      err = 1'b1;
    end
    if (s_f3[1:0] == 2'd1 && s_addr[0])          err = 1'b1;
    if (s_f3[1:0] == 2'd2 && s_addr[1:0] != 2'd0) err = 1'b1;

    word = mem[idx];
    sh   = word >> {s_addr[1:0], 3'b000};
    case (s_f3)
      3'd0:    ld = {{24{sh[7]}}, sh[7:0]};
      3'd1:    ld = {{16{sh[15]}}, sh[15:0]};
      3'd4:    ld = {24'd0, sh[7:0]};
      3'd5:    ld = {16'd0, sh[15:0]};
      default: ld = sh;
    endcase
    rd_next = (err || s_we) ? 32'd0 : ld;

    case (s_f3[1:0])
      2'd0:    begin wmask = 4'b0001 << s_addr[1:0]; wrep = {4{s_wd[7:0]}};  end
      2'd1:    begin wmask = 4'b0011 << s_addr[1:0]; wrep = {2{s_wd[15:0]}}; end
      default: begin wmask = 4'hF;                   wrep = s_wd;            end
    endcase
    do_write = enter && s_we && !err;
  end

  // Store byte lanes on the entry edge; array itself is never reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_write)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      we_q          <= 1'b0;
      f3_q          <= 3'd0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          we_q          <= bus.req_we;
          f3_q          <= bus.req_funct3;
          addr_q        <= bus.req_addr;
          wdata_q       <= bus.req_wdata;
          bus.req_ready <= 1'b0;
          busy          <= 1'b1;
          if (LATENCY > 1) begin
            state <= WAIT;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        RESP: if (bus.rsp_ready) begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          busy          <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (enter) begin
        state         <= RESP;
        bus.rsp_valid <= 1'b1;
        bus.rsp_rdata <= rd_next;
        bus.rsp_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_W=10, LATENCY=2).
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   failures = 0;

  dmem_if bus();

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  // One full transaction: request, measure accept->rsp_valid latency, handshake.
  // lat = -1 when the DUT never accepted or never responded.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    rd = 32'hx; er = 1'bx; lat = -1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin bus.req_valid = 1'b0; return; end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_wdata = 32'h0; bus.req_addr = 32'h0;
    n = 1;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); n++; #1; end
    if (!bus.rsp_valid) return;
    lat = n; rd = bus.rsp_rdata; er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, busy} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b vld=%b rd=%h err=%b busy=%b exp 1 0 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, busy);
    end
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if ({er, rd} !== {1'b0, 32'd0}) begin failures++; $display("FAIL sw_rsp got err=%b rd=%h exp 0 0", er, rd); end
    txn(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin failures++; $display("FAIL lw_data got err=%b rd=%h exp 0 deadbeef", er, rd); end
  endtask

  task automatic test_extend();
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, 3'd0, 32'h13, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFFDE) begin failures++; $display("FAIL lb got=%h exp=ffffffde", rd); end
    txn(1'b0, 3'd4, 32'h13, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h000000DE) begin failures++; $display("FAIL lbu got=%h exp=000000de", rd); end
    txn(1'b0, 3'd1, 32'h12, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFDEAD) begin failures++; $display("FAIL lh got=%h exp=ffffdead", rd); end
    txn(1'b0, 3'd5, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000BEEF) begin failures++; $display("FAIL lhu got=%h exp=0000beef", rd); end
  endtask

  task automatic test_sb();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 3'd0, 32'h11, 32'hFFFFFF55, rd, er, lat);
    txn(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD55EF) begin failures++; $display("FAIL sb_merge got=%h exp=dead55ef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, 3'd2, 32'h12, 32'h0, rd, er, lat);
    checks++; if ({er, rd, lat} !== {1'b1, 32'd0, 32'd2}) begin failures++; $display("FAIL lw_misaligned got err=%b rd=%h lat=%0d exp 1 0 2", er, rd, lat); end
    txn(1'b1, 3'd1, 32'h13, 32'h0000AAAA, rd, er, lat);
    checks++; if ({er, rd, lat} !== {1'b1, 32'd0, 32'd2}) begin failures++; $display("FAIL sh_misaligned got err=%b rd=%h lat=%0d exp 1 0 2", er, rd, lat); end
    txn(1'b0, 3'd3, 32'h10, 32'h0, rd, er, lat);
    checks++; if ({er, rd} !== {1'b1, 32'd0}) begin failures++; $display("FAIL load_f3_3 got err=%b rd=%h exp 1 0", er, rd); end
    txn(1'b1, 3'd4, 32'h10, 32'h77777777, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL store_f3_4 got err=%b exp 1", er); end
    txn(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++; if ({er, rd} !== {1'b0, 32'hDEAD55EF}) begin failures++; $display("FAIL after_err got err=%b rd=%h exp 0 dead55ef", er, rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h10;
    @(posedge clk);
    #1 bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h0BADF00D;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); n++; #1; end
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_timeout got vld=%b exp 1", bus.rsp_valid); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready} !== {1'b1, 32'hDEAD55EF, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold c=%0d got vld=%b rd=%h rdy=%b exp 1 dead55ef 0", c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    checks++; if ({bus.rsp_valid, busy, bus.req_ready} !== {1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL bp_handshake got vld=%b busy=%b rdy=%b exp 0 0 1", bus.rsp_valid, busy, bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 1'b0;
    checks++; if ({busy, bus.req_ready} !== {1'b1, 1'b0}) begin failures++; $display("FAIL bp_reaccept got busy=%b rdy=%b exp 1 0", busy, bus.req_ready); end
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); n++; #1; end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    txn(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL bp_held_store got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h12345678;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_wait_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    txn(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD55EF) begin failures++; $display("FAIL store_dropped got=%h exp=dead55ef", rd); end
    txn(1'b1, 3'd2, 32'h10 + 32'h1000, 32'hCAFEF00D, rd, er, lat);
    txn(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL addr_wrap got=%h exp=cafef00d", rd); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    test_sw_lw();
    test_extend();
    test_sb();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
